// File: rtl/pcileech_tlp_arb_pkg.sv
// Shared types and widths for the PCIe TX round-robin arbiter.
package pcileech_tlp_arb_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    localparam int unsigned QW_W       = 64;
    localparam int unsigned KEEP_W     = 8;
    localparam int unsigned NPORTS_MAX = 8;

    typedef struct packed {
        logic [QW_W-1:0]   data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } tlp_beat_t;

endpackage

// File: rtl/pcileech_rr_pick.sv
// Combinational rotate-priority encoder: first set req bit after ptr, wrapping.
module pcileech_rr_pick #(
    parameter int unsigned NPORTS = 3
) (
    input  logic [NPORTS-1:0]         req_i,
    input  logic [$clog2(NPORTS)-1:0] ptr_i,
    output logic                      found_o,
    output logic [$clog2(NPORTS)-1:0] idx_o
);
    localparam int unsigned IDX_W = $clog2(NPORTS);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NPORTS);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/pcileech_tlp_tx_arbiter.sv
// Packet-atomic round-robin arbiter in front of the PCIe core TX stream.
// Optional per-port packet / stall counters: define TLP_TX_ARB_STATS_EN.
module pcileech_tlp_tx_arbiter
    import pcileech_tlp_arb_pkg::*;
#(
    parameter int unsigned NPORTS = 3,
    parameter int unsigned MAX_QW = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         port_en,
    input  logic [NPORTS-1:0]         s_valid,
    input  logic [NPORTS*64-1:0]      s_data,
    input  logic [NPORTS*8-1:0]       s_keep,
    input  logic [NPORTS-1:0]         s_last,
    output logic [NPORTS-1:0]         s_ready,
    output logic [63:0]               m_data,
    output logic [7:0]                m_keep,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [$clog2(NPORTS)-1:0] grant_id,
    output logic                      busy,
    output logic                      err_overlen
`ifdef TLP_TX_ARB_STATS_EN
    ,
    output logic [NPORTS*16-1:0]      stat_pkt,
    output logic [15:0]               stat_stall
`endif
);
    localparam int unsigned IDX_W = $clog2(NPORTS);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [4:0]       qw_q, qw_d;

    logic [NPORTS-1:0] elig;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    tlp_beat_t         beat;
    logic              beat_valid;
    logic              accept;

    assign elig = port_en & s_valid;

    pcileech_rr_pick #(.NPORTS(NPORTS)) u_pick (
        .req_i   (elig),
        .ptr_i   (rr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Granted source is forwarded combinationally so each beat adds no latency.
    always_comb begin
        beat       = '0;
        beat_valid = 1'b0;
        s_ready    = '0;
        if (state_q == XFER) begin
            beat.data        = s_data[32'(grant_q)*QW_W +: QW_W];
            beat.keep        = s_keep[32'(grant_q)*KEEP_W +: KEEP_W];
            beat.last        = s_last[grant_q];
            beat_valid       = s_valid[grant_q];
            s_ready[grant_q] = m_ready;
        end
    end

    assign accept      = beat_valid & m_ready;
    assign m_data      = beat.data;
    assign m_keep      = beat.keep;
    assign m_last      = beat.last;
    assign m_valid     = beat_valid;
    assign grant_id    = grant_q;
    assign busy        = (state_q == XFER);
    assign err_overlen = accept && (qw_q == 5'(MAX_QW));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        qw_d    = qw_q;
        case (state_q)
            IDLE: begin
                qw_d = '0;
                if (pick_found) begin
                    state_d = XFER;
                    grant_d = pick_idx;
                    rr_d    = pick_idx;
                end
            end
            XFER: begin
                if (accept) begin
                    if (beat.last) begin
                        state_d = IDLE;
                        qw_d    = '0;
                    end else if (qw_q != 5'd31) begin
                        qw_d = qw_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= IDX_W'(NPORTS - 1);
            qw_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            qw_q    <= qw_d;
        end
    end

`ifdef TLP_TX_ARB_STATS_EN
    logic [NPORTS*16-1:0] stat_pkt_q;
    logic [15:0]          stat_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkt_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (accept && beat.last)
                stat_pkt_q[32'(grant_q)*16 +: 16] <= stat_pkt_q[32'(grant_q)*16 +: 16] + 16'd1;
            if (beat_valid && !m_ready)
                stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_pkt   = stat_pkt_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_pcileech_tlp_tx_arbiter.sv
// Randomized self-checking bench for pcileech_tlp_tx_arbiter against a packet-level model.
module tb_pcileech_tlp_tx_arbiter;
    localparam int NP     = 3;
    localparam int MAXQ   = 18;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } tb_beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     port_en = '1;
    logic [NP-1:0]     s_valid = '0;
    logic [NP*64-1:0]  s_data = '0;
    logic [NP*8-1:0]   s_keep = '0;
    logic [NP-1:0]     s_last = '0;
    logic [NP-1:0]     s_ready;
    logic [63:0]       m_data;
    logic [7:0]        m_keep;
    logic              m_last;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_overlen;
`ifdef TLP_TX_ARB_STATS_EN
    logic [NP*16-1:0]  stat_pkt;
    logic [15:0]       stat_stall;
`endif

    pcileech_tlp_tx_arbiter #(.NPORTS(NP), .MAX_QW(MAXQ)) dut (
        .clk(clk), .rst(rst), .port_en(port_en),
        .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .grant_id(grant_id), .busy(busy), .err_overlen(err_overlen)
`ifdef TLP_TX_ARB_STATS_EN
        , .stat_pkt(stat_pkt), .stat_stall(stat_stall)
`endif
    );

    always #8 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Source-side queues (what each source still has to send) and expected copies.
    tb_beat_t src_q[NP][$];
    tb_beat_t exp_q[NP][$];
    logic [NP-1:0] held = '0;
    logic [NP-1:0] acc  = '0;
    int bubble_pct = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
    int ready_pct  = 100;

    // Model state
    bit       mon_en = 1'b0;
    bit       mbusy = 1'b0;
    int       mgrant = 0;
    int       mrr = NP - 1;
    int       beats = 0;
    int       err_pulses = 0;
    int       hold_checks = 0;
    bit       prev_hold = 1'b0;
    tb_beat_t prev_b;
    int       grant_log[$];

    function automatic void enq(input int port, input int len);
        tb_beat_t b;
        for (int n = 0; n < len; n++) begin
            b.d = {$urandom, $urandom};
            b.k = ($urandom_range(1) == 0) ? 8'h0f : 8'hff;
            b.l = (n == len - 1);
            src_q[port].push_back(b);
            exp_q[port].push_back(b);
        end
    endfunction

    // Source drivers: once valid is raised a beat is held until accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                held[i] = 1'b0;
            end
            if (src_q[i].size() == 0) held[i] = 1'b0;
            else if (!held[i] && $urandom_range(99) >= 32'(bubble_pct)) held[i] = 1'b1;
            s_valid[i] = held[i];
            if (held[i]) begin
                s_data[64*i +: 64] = src_q[i][0].d;
                s_keep[8*i +: 8]   = src_q[i][0].k;
                s_last[i]          = src_q[i][0].l;
            end else begin
                s_data[64*i +: 64] = {$urandom, $urandom};
                s_keep[8*i +: 8]   = 8'h00;
                s_last[i]          = 1'($urandom_range(1));
            end
        end
        acc = '0;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = ($urandom_range(99) < 32'(ready_pct));
        endcase
    end

    // Packet-level reference: round-robin over eligible sources, one idle cycle per packet.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (!mbusy) begin
                checks++;
                if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== '0 || err_overlen !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: m_valid=%b busy=%b s_ready=%b err=%b expected 0,0,000,0",
                             m_valid, busy, s_ready, err_overlen);
                end
                for (int k = 1; k <= NP; k++) begin
                    int j;
                    j = (mrr + k) % NP;
                    if (!mbusy && port_en[j] && s_valid[j]) begin
                        mbusy = 1'b1;
                        mgrant = j;
                        mrr = j;
                        beats = 0;
                        prev_hold = 1'b0;
                        grant_log.push_back(j);
                    end
                end
            end else begin
                checks++;
                if (busy !== 1'b1 || grant_id !== 2'(mgrant)) begin
                    errors++;
                    $display("FAIL grant: busy=%b grant_id=%0d expected busy=1 grant=%0d", busy, grant_id, mgrant);
                end
                checks++;
                if (s_ready !== (NP'(m_ready) << mgrant)) begin
                    errors++;
                    $display("FAIL s_ready: got %b expected %b", s_ready, NP'(m_ready) << mgrant);
                end
                checks++;
                if (m_valid !== s_valid[mgrant]) begin
                    errors++;
                    $display("FAIL m_valid_follow: got %b expected %b", m_valid, s_valid[mgrant]);
                end
                if (prev_hold) begin
                    checks++;
                    hold_checks++;
                    if (m_valid !== 1'b1 || m_data !== prev_b.d || m_keep !== prev_b.k || m_last !== prev_b.l) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, prev_b.d);
                    end
                end
                if (m_valid === 1'b1 && m_ready === 1'b1) begin
                    tb_beat_t e;
                    beats++;
                    checks++;
                    if (exp_q[mgrant].size() == 0) begin
                        errors++;
                        $display("FAIL beat_data: port %0d produced an unexpected beat d=%h", mgrant, m_data);
                        mbusy = 1'b0;
                    end else begin
                        e = exp_q[mgrant].pop_front();
                        if (m_data !== e.d || m_keep !== e.k || m_last !== e.l) begin
                            errors++;
                            $display("FAIL beat_data: port %0d beat %0d got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                                     mgrant, beats, m_data, m_keep, m_last, e.d, e.k, e.l);
                        end
                        if (e.l) mbusy = 1'b0;
                    end
                    checks++;
                    if (err_overlen !== (beats == MAXQ + 1)) begin
                        errors++;
                        $display("FAIL err_overlen: beat %0d got %b expected %b", beats, err_overlen, beats == MAXQ + 1);
                    end
                end else begin
                    checks++;
                    if (err_overlen !== 1'b0) begin
                        errors++;
                        $display("FAIL err_overlen_idle: got %b expected 0", err_overlen);
                    end
                end
                prev_hold = (m_valid === 1'b1 && m_ready === 1'b0);
                prev_b    = '{d: m_data, k: m_keep, l: m_last};
            end
            if (err_overlen === 1'b1) err_pulses++;
            acc = s_valid & s_ready;
        end
    end

    function automatic bit all_drained();
        bit e;
        e = !mbusy;
        for (int i = 0; i < NP; i++) e = e && (src_q[i].size() == 0) && (exp_q[i].size() == 0);
        return e;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!all_drained() && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (!all_drained()) begin
            errors++;
            $display("FAIL %s_timeout: not drained after %0d cycles, expected drained", name, budget);
        end
    endtask

    task automatic start_point();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== '0 || m_last !== 1'b0 || s_ready !== '0 ||
            grant_id !== '0 || busy !== 1'b0 || err_overlen !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: v=%b d=%h k=%h l=%b rdy=%b g=%0d busy=%b err=%b expected all 0",
                     m_valid, m_data, m_keep, m_last, s_ready, grant_id, busy, err_overlen);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_order();
        int base;
        base = grant_log.size();
        start_point();
        for (int p = 0; p < NP; p++) enq(p, 3);
        wait_drain("order", 200);
        checks++;
        if (grant_log.size() != base + 3 || grant_log[base] != 0 || grant_log[base+1] != 1 || grant_log[base+2] != 2) begin
            errors++;
            $display("FAIL order: got %0d grants starting %0d, expected 3 grants 0,1,2",
                     grant_log.size() - base, (grant_log.size() > base) ? grant_log[base] : -1);
        end
    endtask

    task automatic test_fairness();
        int base, pos;
        base = grant_log.size();
        start_point();
        for (int n = 0; n < 10; n++) enq(0, 2);
        enq(2, 4);
        wait_drain("fairness", 400);
        pos = -1;
        for (int i = base; i < grant_log.size(); i++) if (grant_log[i] == 2 && pos < 0) pos = i - base;
        checks++;
        if (pos < 0 || pos > 2) begin
            errors++;
            $display("FAIL fairness: port 2 granted at position %0d, expected 0..2", pos);
        end
    endtask

    task automatic test_backpressure();
        int h0;
        h0 = hold_checks;
        ready_mode = 1;
        start_point();
        enq(1, 4);
        wait_drain("backpressure", 200);
        ready_mode = 0;
        checks++;
        if (hold_checks - h0 < 1) begin
            errors++;
            $display("FAIL backpressure_stall: got %0d stalled beats, expected at least 1", hold_checks - h0);
        end
    endtask

    task automatic test_port_en();
        int base, n, left;
        base = grant_log.size();
        start_point();
        enq(1, 6);
        enq(1, 2);
        n = 0;
        while (!(mbusy && mgrant == 1 && beats >= 2) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        port_en[1] = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        left = src_q[1].size();
        checks++;
        if (grant_log.size() != base + 1 || busy !== 1'b0 || left != 2) begin
            errors++;
            $display("FAIL port_en_hold: got grants=%0d busy=%b port1_left=%0d expected 1,0,2",
                     grant_log.size() - base, busy, left);
        end
        port_en[1] = 1'b1;
        wait_drain("port_en", 200);
        checks++;
        if (grant_log.size() != base + 2 || grant_log[grant_log.size()-1] != 1) begin
            errors++;
            $display("FAIL port_en_resume: got %0d grants, expected 2 on port 1", grant_log.size() - base);
        end
    endtask

    task automatic test_overlen();
        int e0;
        e0 = err_pulses;
        start_point();
        enq(0, MAXQ + 1);
        wait_drain("overlen", 300);
        checks++;
        if (err_pulses - e0 != 1) begin
            errors++;
            $display("FAIL overlen_pulses: got %0d pulses, expected 1", err_pulses - e0);
        end
    endtask

    task automatic test_random();
        int base;
        base = grant_log.size();
        bubble_pct = 30;
        ready_mode = 2;
        ready_pct = 70;
        start_point();
        for (int n = 0; n < 30; n++) enq($urandom_range(NP - 1), $urandom_range(8, 1));
        wait_drain("random", 5000);
        bubble_pct = 0;
        ready_mode = 0;
        checks++;
        if (grant_log.size() - base != 30) begin
            errors++;
            $display("FAIL random_packets: got %0d grants, expected 30", grant_log.size() - base);
        end
    endtask

    task automatic test_reset_mid();
        int n, base;
        start_point();
        enq(1, 4);
        n = 0;
        while (!(mbusy && mgrant == 1 && beats >= 1) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #3;
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== '0) begin
            errors++;
            $display("FAIL reset_async: v=%b busy=%b rdy=%b expected 0,0,000", m_valid, busy, s_ready);
        end
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        held = '0;
        acc = '0;
        mbusy = 1'b0;
        mrr = NP - 1;
        prev_hold = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1'b1;
        base = grant_log.size();
        start_point();
        enq(1, 2);
        enq(0, 2);
        wait_drain("reset_mid", 200);
        checks++;
        if (grant_log.size() != base + 2 || grant_log[base] != 0) begin
            errors++;
            $display("FAIL reset_first_grant: got first grant %0d, expected 0",
                     (grant_log.size() > base) ? grant_log[base] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_fairness();
        test_backpressure();
        test_port_en();
        test_overlen();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
